// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch controller feeding the uart Tx_DATA/Tx_WR/Tx_BUSY handshake.
// Optional feature macro: UART_TXF_DROP_CNT_EN adds the saturating drop_cnt overflow counter port.
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              enable,
    input  logic              Tx_BUSY,
    output logic              Tx_WR,
    output logic [7:0]        Tx_DATA,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
`ifdef UART_TXF_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int unsigned    CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL_LVL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                push;
    logic                pop;
    logic [ADDR_W:0]     count_next;

    // Push/pop qualification and next occupancy; full is the registered flag so a push at full drops.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        count_next = count;
        push       = wr_en && !full;
        pop        = (state == IDLE) && enable && !empty && !Tx_BUSY;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags derived from the next count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_LVL);
            empty <= (count_next == '0);
        end
    end

    // Launch FSM: pop into Tx_DATA, hold Tx_WR until the uart reports busy, then wait for it to finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            Tx_WR   <= 1'b0;
            Tx_DATA <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_DATA <= mem[rd_ptr];
                        Tx_WR   <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (Tx_BUSY) begin
                        Tx_WR <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!Tx_BUSY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    Tx_WR <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXF_DROP_CNT_EN
    // Saturating count of pushes refused because the FIFO was full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= 8'h00;
        end else if (wr_en && full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule
